// File: rtl/hxd_arb_pkg.sv
// Shared types and sizing helpers for the data-RAM arbiter.
package hxd_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_OWN_CPU  = 2'd1,
        ARB_OWN_HOST = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_CPU  = 1'b0,
        ARB_HOST = 1'b1
    } arb_id_t;

    // Default burst limit and the matching counter width.
    localparam int ARB_MAX_BURST = 16;
    localparam int ARB_BCNT_W    = $clog2(ARB_MAX_BURST + 1);

    // Counter width needed to hold values 0..max_burst inclusive.
    function automatic int arb_bcnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/dram_arb.sv
// Two-requester arbiter for the single data-RAM port: CPU (requester 0)
// and the UART debug/loader host (requester 1). Ownership is registered,
// ties go to whoever did not own last, bursts are bounded unless locked,
// and 1-cycle read data is tagged back to the issuing requester.
module dram_arb
    import hxd_arb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MAX_BURST = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cpu_req_i,
    input  logic            cpu_we_i,
    input  logic [XLEN-1:0] cpu_addr_i,
    input  logic [XLEN-1:0] cpu_wdata_i,
    input  logic [3:0]      cpu_be_i,
    input  logic            cpu_lock_i,
    output logic            cpu_gnt_o,
    output logic            cpu_rvalid_o,
    input  logic            host_req_i,
    input  logic            host_we_i,
    input  logic [XLEN-1:0] host_addr_i,
    input  logic [XLEN-1:0] host_wdata_i,
    input  logic [3:0]      host_be_i,
    input  logic            host_lock_i,
    output logic            host_gnt_o,
    output logic            host_rvalid_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            ram_en_o,
    output logic [3:0]      ram_we_o,
    output logic [XLEN-1:0] ram_addr_o,
    output logic [XLEN-1:0] ram_wdata_o,
    input  logic [XLEN-1:0] ram_rdata_i
);

    localparam int BCNT_W = arb_bcnt_w(MAX_BURST);
    localparam logic [BCNT_W-1:0] BURST_MAX = BCNT_W'(MAX_BURST);

    arb_state_t        state_q;
    arb_id_t           last_owner_q;
    logic [BCNT_W-1:0] burst_cnt_q;
    logic              cpu_rvalid_q;
    logic              host_rvalid_q;

    logic              cpu_gnt;
    logic              host_gnt;
    logic              own_req;
    logic              own_lock;
    logic              oth_req;
    arb_id_t           own_id;
    arb_state_t        oth_state;
    logic [BCNT_W-1:0] burst_cnt_d;
    logic              burst_hit;

    // Saturating increment of the burst counter.
    function automatic logic [BCNT_W-1:0] burst_sat_inc(input logic [BCNT_W-1:0] c);
        if (c >= BURST_MAX) return c;
        return c + BCNT_W'(1);
    endfunction

    assign cpu_gnt  = (state_q == ARB_OWN_CPU)  && cpu_req_i;
    assign host_gnt = (state_q == ARB_OWN_HOST) && host_req_i;

    // Owner-relative view of the request lines and the RAM port mux.
    always_comb begin
        own_req     = 1'b0;
        own_lock    = 1'b0;
        oth_req     = 1'b0;
        own_id      = ARB_CPU;
        oth_state   = ARB_OWN_HOST;
        ram_en_o    = 1'b0;
        ram_we_o    = 4'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (state_q == ARB_OWN_HOST) begin
            own_req   = host_req_i;
            own_lock  = host_lock_i;
            oth_req   = cpu_req_i;
            own_id    = ARB_HOST;
            oth_state = ARB_OWN_CPU;
        end else begin
            own_req   = cpu_req_i;
            own_lock  = cpu_lock_i;
            oth_req   = host_req_i;
        end
        if (cpu_gnt) begin
            ram_en_o    = 1'b1;
            ram_we_o    = cpu_we_i ? cpu_be_i : 4'b0;
            ram_addr_o  = cpu_addr_i;
            ram_wdata_o = cpu_wdata_i;
        end else if (host_gnt) begin
            ram_en_o    = 1'b1;
            ram_we_o    = host_we_i ? host_be_i : 4'b0;
            ram_addr_o  = host_addr_i;
            ram_wdata_o = host_wdata_i;
        end
        burst_cnt_d = (cpu_gnt || host_gnt) ? burst_sat_inc(burst_cnt_q) : burst_cnt_q;
        burst_hit   = (burst_cnt_d == BURST_MAX);
    end

    // Ownership FSM, burst counter and read-return tags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ARB_IDLE;
            last_owner_q  <= ARB_HOST;
            burst_cnt_q   <= '0;
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q  <= cpu_gnt  && !cpu_we_i;
            host_rvalid_q <= host_gnt && !host_we_i;
            case (state_q)
                ARB_IDLE: begin
                    burst_cnt_q <= '0;
                    if (cpu_req_i && host_req_i)
                        state_q <= (last_owner_q == ARB_CPU) ? ARB_OWN_HOST : ARB_OWN_CPU;
                    else if (cpu_req_i)
                        state_q <= ARB_OWN_CPU;
                    else if (host_req_i)
                        state_q <= ARB_OWN_HOST;
                end
                ARB_OWN_CPU, ARB_OWN_HOST: begin
                    if (own_lock) begin
                        // Lock holds ownership regardless of the burst limit.
                        burst_cnt_q <= burst_cnt_d;
                    end else if (!own_req) begin
                        state_q      <= oth_req ? oth_state : ARB_IDLE;
                        last_owner_q <= own_id;
                        burst_cnt_q  <= '0;
                    end else if (burst_hit && oth_req) begin
                        // This beat was the owner's last; hand over with no gap.
                        state_q      <= oth_state;
                        last_owner_q <= own_id;
                        burst_cnt_q  <= '0;
                    end else begin
                        burst_cnt_q <= burst_cnt_d;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign cpu_gnt_o     = cpu_gnt;
    assign host_gnt_o    = host_gnt;
    assign cpu_rvalid_o  = cpu_rvalid_q;
    assign host_rvalid_o = host_rvalid_q;
    assign rdata_o       = ram_rdata_i;

endmodule

// File: tb/tb_dram_arb.sv
// Directed bench for dram_arb with a small byte-enabled RAM model.
module tb_dram_arb;

    localparam int XLEN      = 32;
    localparam int MAX_BURST = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            cpu_req, cpu_we, cpu_lock;
    logic [XLEN-1:0] cpu_addr, cpu_wdata;
    logic [3:0]      cpu_be;
    logic            cpu_gnt, cpu_rvalid;
    logic            host_req, host_we, host_lock;
    logic [XLEN-1:0] host_addr, host_wdata;
    logic [3:0]      host_be;
    logic            host_gnt, host_rvalid;
    logic [XLEN-1:0] rdata;
    logic            ram_en;
    logic [3:0]      ram_we;
    logic [XLEN-1:0] ram_addr, ram_wdata, ram_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    dram_arb #(.XLEN(XLEN), .MAX_BURST(MAX_BURST)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_be_i(cpu_be), .cpu_lock_i(cpu_lock),
        .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_wdata_i(host_wdata), .host_be_i(host_be), .host_lock_i(host_lock),
        .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
        .rdata_o(rdata),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    // RAM model: reset preloads mem[i] = A000_0000 + i, except mem[0x10].
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
            mem[16]   <= 32'h1234_5678;
            ram_rdata <= '0;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            if (ram_we == 4'b0) ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        host_req = 0; host_we = 0; host_lock = 0; host_addr = '0; host_wdata = '0; host_be = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        repeat (2) tick();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();

        // CPU-only read at 0x10
        do_reset();
        #1;
        check_val("rst_gnt",    {cpu_gnt, host_gnt}, 2'b00);
        check_val("rst_rvalid", {cpu_rvalid, host_rvalid}, 2'b00);
        check_val("rst_ram_en", ram_en, 1'b0);
        check_val("rst_ram_we", ram_we, 4'h0);
        check_val("rst_addr",   ram_addr, 32'h0);
        check_val("rst_wdata",  ram_wdata, 32'h0);
        cpu_req = 1; cpu_addr = 32'h10;
        #1;
        check_val("t1_c0_gnt", cpu_gnt, 1'b0);
        tick();
        #1;
        check_val("t1_c1_gnt",   cpu_gnt, 1'b1);
        check_val("t1_c1_en",    ram_en, 1'b1);
        check_val("t1_c1_addr",  ram_addr, 32'h10);
        check_val("t1_c1_we",    ram_we, 4'h0);
        tick();
        cpu_req = 0;
        #1;
        check_val("t1_c2_rvalid", cpu_rvalid, 1'b1);
        check_val("t1_c2_rdata",  rdata, 32'h1234_5678);
        tick();
        #1;
        check_val("t1_c3_rvalid", cpu_rvalid, 1'b0);

        // Simultaneous first requests: CPU write, HOST read
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hdeadbeef; cpu_be = 4'hf;
        host_req = 1; host_we = 0; host_addr = 32'h10;
        #1;
        check_val("t2_c0_gnt", {cpu_gnt, host_gnt}, 2'b00);
        tick();
        #1;
        check_val("t2_c1_gnt",   {cpu_gnt, host_gnt}, 2'b10);
        check_val("t2_c1_we",    ram_we, 4'hf);
        check_val("t2_c1_wdata", ram_wdata, 32'hdeadbeef);
        check_val("t2_c1_addr",  ram_addr, 32'h20);
        tick();
        cpu_req = 0;
        #1;
        check_val("t2_c2_mem", mem[8'h20], 32'hdeadbeef);
        check_val("t2_c2_gnt", {cpu_gnt, host_gnt}, 2'b00);
        check_val("t2_c2_cpu_rvalid", cpu_rvalid, 1'b0);
        tick();
        #1;
        check_val("t2_c3_gnt",  {cpu_gnt, host_gnt}, 2'b01);
        check_val("t2_c3_addr", ram_addr, 32'h10);
        check_val("t2_c3_we",   ram_we, 4'h0);
        tick();
        host_req = 0;
        #1;
        check_val("t2_c4_rvalid", {cpu_rvalid, host_rvalid}, 2'b01);
        check_val("t2_c4_rdata",  rdata, 32'h1234_5678);

        // Fairness: both held high, alternating bursts of 16
        do_reset();
        cpu_req = 1; cpu_addr = 32'h1; host_req = 1; host_addr = 32'h2;
        #1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            #1;
            check_val($sformatf("t3_fair_c%0d", k), {cpu_gnt, host_gnt},
                      (((k - 1) / 16) % 2 == 0) ? 2'b10 : 2'b01);
        end
        idle_inputs();

        // HOST lock over 40 write beats while CPU requests
        do_reset();
        host_req = 1; host_lock = 1; host_we = 1; host_be = 4'hf;
        host_addr = 32'h40; host_wdata = 32'h0;
        #1;
        tick();
        cpu_req = 1; cpu_addr = 32'h5;
        for (int i = 0; i < 40; i++) begin
            host_addr = 32'h40 + i; host_wdata = i;
            #1;
            check_val($sformatf("t4_lock_b%0d", i), {cpu_gnt, host_gnt}, 2'b01);
            tick();
        end
        host_req = 0; host_lock = 0; host_we = 0;
        #1;
        check_val("t4_release_gnt", {cpu_gnt, host_gnt}, 2'b00);
        check_val("t4_mem_last",    mem[8'h67], 32'd39);
        tick();
        #1;
        check_val("t4_cpu_gnt", {cpu_gnt, host_gnt}, 2'b10);
        idle_inputs();

        // Interleaved reads at a burst-limit handover
        do_reset();
        cpu_req = 1; cpu_addr = 32'h30; host_req = 1; host_addr = 32'h10;
        #1;
        repeat (16) tick();
        #1;
        check_val("t5_c16_gnt", {cpu_gnt, host_gnt}, 2'b10);
        tick();
        #1;
        check_val("t5_c17_gnt",    {cpu_gnt, host_gnt}, 2'b01);
        check_val("t5_c17_rvalid", {cpu_rvalid, host_rvalid}, 2'b10);
        check_val("t5_c17_rdata",  rdata, 32'hA000_0030);
        tick();
        cpu_req = 0; host_req = 0;
        #1;
        check_val("t5_c18_rvalid", {cpu_rvalid, host_rvalid}, 2'b01);
        check_val("t5_c18_rdata",  rdata, 32'h1234_5678);

        // Reset sampled on the edge after a read grant
        do_reset();
        cpu_req = 1; cpu_addr = 32'h10;
        #1;
        tick();
        #1;
        check_val("t6_c1_gnt", cpu_gnt, 1'b1);
        rst = 1;
        tick();
        rst = 0; cpu_req = 0;
        #1;
        check_val("t6_c2_rvalid", {cpu_rvalid, host_rvalid}, 2'b00);
        check_val("t6_c2_gnt",    {cpu_gnt, host_gnt}, 2'b00);
        check_val("t6_c2_en",     ram_en, 1'b0);
        check_val("t6_c2_addr",   ram_addr, 32'h0);
        tick();
        cpu_req = 1;
        #1;
        check_val("t6_c3_rvalid", cpu_rvalid, 1'b0);
        check_val("t6_c3_idle",   cpu_gnt, 1'b0);
        tick();
        #1;
        check_val("t6_c4_gnt", cpu_gnt, 1'b1);
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
